// File: rtl/pmem_arbiter.sv
// Arbitrates the single pmem port between I-cache and D-cache line misses.
// Optional round-robin tie-breaking is enabled by defining PMEM_ARB_ROUND_ROBIN_EN.
module pmem_arbiter #(
  parameter int unsigned ADDR_WIDTH = 16,
  parameter int unsigned LINE_WIDTH = 128
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  icache_pmem_read,
  input  logic [ADDR_WIDTH-1:0] icache_pmem_address,
  output logic [LINE_WIDTH-1:0] icache_pmem_rdata,
  output logic                  icache_pmem_resp,
  input  logic                  dcache_pmem_read,
  input  logic                  dcache_pmem_write,
  input  logic [ADDR_WIDTH-1:0] dcache_pmem_address,
  input  logic [LINE_WIDTH-1:0] dcache_pmem_wdata,
  output logic [LINE_WIDTH-1:0] dcache_pmem_rdata,
  output logic                  dcache_pmem_resp,
  output logic                  mem_read,
  output logic                  mem_write,
  output logic [ADDR_WIDTH-1:0] mem_address,
  output logic [LINE_WIDTH-1:0] mem_wdata,
  input  logic [LINE_WIDTH-1:0] mem_rdata,
  input  logic                  mem_resp
);

  typedef enum logic [1:0] {StIdle, StServeI, StServeD} state_e;

  state_e                state_q, state_d;
  logic                  mem_read_q, mem_read_d;
  logic                  mem_write_q, mem_write_d;
  logic [ADDR_WIDTH-1:0] mem_address_q, mem_address_d;
  logic [LINE_WIDTH-1:0] mem_wdata_q, mem_wdata_d;
  logic                  d_req;
  logic                  grant_d;

  assign d_req = dcache_pmem_read | dcache_pmem_write;

`ifdef PMEM_ARB_ROUND_ROBIN_EN
  // last_d_q set means D was granted most recently; on a tie the other side wins.
  logic last_d_q, last_d_d;

  assign grant_d = d_req & (~icache_pmem_read | ~last_d_q);

  always_ff @(posedge clk) begin
    if (reset) begin
      last_d_q <= 1'b0;
    end else begin
      last_d_q <= last_d_d;
    end
  end

  always_comb begin
    last_d_d = last_d_q;
    if (state_q == StIdle) begin
      if (grant_d) begin
        last_d_d = 1'b1;
      end else if (icache_pmem_read) begin
        last_d_d = 1'b0;
      end
    end
  end
`else
  assign grant_d = d_req;
`endif

  always_comb begin
    state_d       = state_q;
    mem_read_d    = mem_read_q;
    mem_write_d   = mem_write_q;
    mem_address_d = mem_address_q;
    mem_wdata_d   = mem_wdata_q;
    case (state_q)
      StIdle: begin
        if (grant_d) begin
          // A write beats a simultaneous read so the strobes stay mutually exclusive.
          state_d       = StServeD;
          mem_write_d   = dcache_pmem_write;
          mem_read_d    = ~dcache_pmem_write;
          mem_address_d = dcache_pmem_address;
          mem_wdata_d   = dcache_pmem_wdata;
        end else if (icache_pmem_read) begin
          state_d       = StServeI;
          mem_write_d   = 1'b0;
          mem_read_d    = 1'b1;
          mem_address_d = icache_pmem_address;
        end
      end
      StServeI, StServeD: begin
        if (mem_resp) begin
          state_d     = StIdle;
          mem_read_d  = 1'b0;
          mem_write_d = 1'b0;
        end
      end
      default: begin
        state_d     = StIdle;
        mem_read_d  = 1'b0;
        mem_write_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= StIdle;
      mem_read_q    <= 1'b0;
      mem_write_q   <= 1'b0;
      mem_address_q <= '0;
      mem_wdata_q   <= '0;
    end else begin
      state_q       <= state_d;
      mem_read_q    <= mem_read_d;
      mem_write_q   <= mem_write_d;
      mem_address_q <= mem_address_d;
      mem_wdata_q   <= mem_wdata_d;
    end
  end

  assign mem_read          = mem_read_q;
  assign mem_write         = mem_write_q;
  assign mem_address       = mem_address_q;
  assign mem_wdata         = mem_wdata_q;
  assign icache_pmem_rdata = mem_rdata;
  assign dcache_pmem_rdata = mem_rdata;
  assign icache_pmem_resp  = (state_q == StServeI) & mem_resp;
  assign dcache_pmem_resp  = (state_q == StServeD) & mem_resp;

endmodule

// File: doc/pmem_arbiter.md
Name: pmem_arbiter

Overview:
- Arbitrates the single physical-memory (L2/pmem) port between I-cache and D-cache miss traffic in the pipelined LC-3b.
- Line-granular transfers only.
- Grants one requester at a time.
- Latches the granted request's address, data and direction so the downstream request stays stable for the whole transaction.
- Routes the response back to the granted requester only.

Parameters:
ADDR_WIDTH, 16, byte address width of line requests
LINE_WIDTH, 128, cache line width in bits

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-high reset
icache_pmem_read  in  1  I-cache line read request, held until resp
icache_pmem_address  in  ADDR_WIDTH  I-cache line address
icache_pmem_rdata  out  LINE_WIDTH  read data to I-cache
icache_pmem_resp  out  1  one-cycle completion pulse to I-cache
dcache_pmem_read  in  1  D-cache line read request, held until resp
dcache_pmem_write  in  1  D-cache line writeback request, held until resp
dcache_pmem_address  in  ADDR_WIDTH  D-cache line address
dcache_pmem_wdata  in  LINE_WIDTH  D-cache writeback data
dcache_pmem_rdata  out  LINE_WIDTH  read data to D-cache
dcache_pmem_resp  out  1  one-cycle completion pulse to D-cache
mem_read  out  1  downstream read strobe, held until mem_resp
mem_write  out  1  downstream write strobe, held until mem_resp
mem_address  out  ADDR_WIDTH  downstream address (registered)
mem_wdata  out  LINE_WIDTH  downstream write data (registered)
mem_rdata  in  LINE_WIDTH  downstream read data, valid with mem_resp
mem_resp  in  1  downstream completion pulse

Behaviour:
- Clocking: one clock; reset is synchronous and active-high.
- States: IDLE, SERVE_I, SERVE_D.
- Reset values: state IDLE; mem_read, mem_write, mem_address, mem_wdata all 0; both resp outputs 0.
- IDLE:
  - If dcache_pmem_read or dcache_pmem_write is asserted: go to SERVE_D. Latch dcache address, wdata and direction.
  - Else if icache_pmem_read is asserted: go to SERVE_I. Latch icache address. Latched direction is read.
  - Fixed priority: D over I.
- Latency: a request seen at edge N drives mem_read/mem_write from cycle N+1.
- SERVE_x:
  - Hold the latched mem_* values; ignore changes on requester inputs.
  - When mem_resp=1: pulse x_pmem_resp in the same cycle (combinational from state and mem_resp), then go to IDLE.
  - mem_read and mem_write deassert in the cycle after mem_resp.
- Both *_pmem_rdata outputs carry mem_rdata directly. Only resp is gated by grant.
- At least one IDLE cycle separates consecutive grants. This guarantees a requester has dropped its request before re-arbitration; a stale request is never re-served.
- If dcache read and write are both asserted, write wins (protocol violation, defined here for determinism).
- A requester that drops its request mid-transaction is not aborted. The grant completes on mem_resp; the resp pulse is still issued.
- mem_resp in IDLE is ignored: no resp pulse, no state change.
- Reset mid-transaction:
  - Next cycle: state IDLE, mem strobes 0.
  - Any later mem_resp for the abandoned transaction is ignored.
  - Downstream must tolerate an abandoned transaction.
- mem_read and mem_write are never asserted together.
- At most one resp output is high in any cycle.

Optional Feature:
- Macro: PMEM_ARB_ROUND_ROBIN_EN.
- Defined:
  - A 1-bit last-grant register (reset: I, so D wins the first tie).
  - On simultaneous pending requests in IDLE, grant the requester not served last.
  - A single pending request is granted immediately.
  - Last-grant updates at each grant.
- Undefined: fixed D-over-I priority as above; no last-grant register.

Test Plan:
- Single I-cache read:
  - Stimulus: icache_pmem_read=1, addr 0x1230 at cycle 0; mem_resp=1 with rdata 0xDEAD...BEEF at cycle 5.
  - Required: mem_read=1, mem_address=0x1230 in cycles 1-5; icache_pmem_resp=1 only at cycle 5 with matching rdata; dcache_pmem_resp=0 throughout; mem_read=0 at cycle 6.
- Simultaneous requests, no macro:
  - Stimulus: I read 0x1000 and D read 0x2000 both at cycle 0; each requester drops after its resp.
  - Required: D served first with mem_address=0x2000; one IDLE cycle; then I served with mem_address=0x1000; total two resp pulses.
- D writeback:
  - Stimulus: dcache_pmem_write, addr 0x4000, wdata 0xA5A5...A5; change dcache wdata to 0 mid-transaction.
  - Required: mem_write=1, mem_read=0, mem_wdata stays 0xA5A5...A5 until mem_resp; dcache_pmem_resp pulses once.
- Reset mid-transaction:
  - Stimulus: reset in cycle 3 of SERVE_I; mem_resp arrives at cycle 6 with icache request re-held low.
  - Required: mem_read=0 from cycle 4; no icache_pmem_resp at cycle 6.
- Spurious response:
  - Stimulus: mem_resp=1 while IDLE with no requests.
  - Required: both resp outputs 0; mem_read=mem_write=0.
- Continuous contention:
  - Stimulus: I and D requests held high continuously for 4 transactions.
  - Required with PMEM_ARB_ROUND_ROBIN_EN: grant order D,I,D,I.
  - Required without it: D,D,D,D (icache_pmem_resp never pulses).
